// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: run/hold/stop sequencer for the demo counter datapath.
// A prescaler turns RUN cycles into count steps (one step every DIV cycles).
// A four-state FSM loads, runs, pauses and terminates the count.
module counter_seq_ctrl #(
  parameter int DIV   = 50_000_000,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             up,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    pre, pre_nx;
  logic [WIDTH-1:0] q_nx, step_val;
  logic [WIDTH-1:0] load_l, load_nx, lim_l, lim_nx;
  logic             up_l, up_nx, mode_l, mode_nx;
  logic             tick_nx, tc_nx;

  // Value after one step: continuous mode reloads at the terminal value,
  // otherwise count up or down with natural modulo-2^WIDTH wrap.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic [WIDTH-1:0] lim,
    input logic             dir_up,
    input logic             cont
  );
    if (cont && (cur == lim)) return ld;
    else if (dir_up)          return cur + WIDTH'(1);
    else                      return cur - WIDTH'(1);
  endfunction

  // Candidate count value should a step occur this edge.
  always_comb step_val = next_count(q, load_l, lim_l, up_l, mode_l);

  // Next-state, prescaler and datapath decisions; stop > start > hold > step.
  always_comb begin
    state_nx = state;
    pre_nx   = pre;
    q_nx     = q;
    load_nx  = load_l;
    lim_nx   = lim_l;
    up_nx    = up_l;
    mode_nx  = mode_l;
    tick_nx  = 1'b0;
    tc_nx    = 1'b0;
    if (stop) begin
      state_nx = IDLE;
      pre_nx   = '0;
    end else if (start && ((state == IDLE) || (state == DONE))) begin
      state_nx = RUN;
      pre_nx   = '0;
      q_nx     = load_val;
      load_nx  = load_val;
      lim_nx   = limit;
      up_nx    = up;
      mode_nx  = mode;
    end else if ((state == RUN) && hold) begin
      state_nx = HOLD;
    end else if ((state == RUN) || ((state == HOLD) && !hold)) begin
      // Leaving HOLD behaves like a normal RUN edge so a hold of H cycles
      // delays later steps by exactly H cycles.
      state_nx = RUN;
      if (pre == PRE_LAST) begin
        pre_nx  = '0;
        q_nx    = step_val;
        tick_nx = 1'b1;
        if (step_val == lim_l) begin
          tc_nx = 1'b1;
          if (!mode_l) state_nx = DONE;
        end
      end else begin
        pre_nx = pre + PW'(1);
      end
    end
  end

  // State, datapath and registered status flags (decoded from next state).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pre    <= '0;
      q      <= '0;
      load_l <= '0;
      lim_l  <= '0;
      up_l   <= 1'b0;
      mode_l <= 1'b0;
      tick   <= 1'b0;
      tc     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      pre    <= pre_nx;
      q      <= q_nx;
      load_l <= load_nx;
      lim_l  <= lim_nx;
      up_l   <= up_nx;
      mode_l <= mode_nx;
      tick   <= tick_nx;
      tc     <= tc_nx;
      busy   <= (state_nx == RUN) || (state_nx == HOLD);
      done   <= (state_nx == DONE);
    end
  end

endmodule
